// File: rtl/systolic_drain_pkg.sv
// Shared definitions for the systolic array feeder and drain blocks:
// default array geometry, the control state encoding and the last skew index.
package systolic_pkg;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int SKEW_LAST = ROWS + COLS - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/systolic_drain_if.sv
// Row-byte stream leaving the drain block: valid/ready handshake plus data.
interface systolic_drain_if #(
    parameter int COLS = 8
);
    logic [COLS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/systolic_drain_deskew_buffer.sv
// ROWS x COLS bit store that undoes the column skew of the systolic array.
// At skew index k, column j carries row k-j, so bit [k-j][j] is written when
// that row exists; all other bits keep their value.
module deskew_buffer #(
    parameter int COLS  = 8,
    parameter int ROWS  = 8,
    parameter int K_W   = 4,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [K_W-1:0]   i_k,
    input  logic [COLS-1:0]  i_sys_in,
    input  logic [ROW_W-1:0] i_rd_row,
    output logic [COLS-1:0]  o_rd_data
);

    logic [COLS-1:0] r_buf [ROWS];

    // Per-bit write enable decoded from the skew index: row r, column j is
    // live exactly when k == r + j.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                r_buf[r] <= '0;
            end
        end else if (i_wr_en) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < COLS; j++) begin
                    if (int'(i_k) == r + j) begin
                        r_buf[r][j] <= i_sys_in[j];
                    end
                end
            end
        end
    end

    assign o_rd_data = r_buf[i_rd_row];

endmodule

// File: rtl/systolic_drain.sv
// Drain side of the 1-bit systolic array: captures one skewed wavefront into
// the de-skew buffer, then streams it out one row-byte per handshake.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int COLS = systolic_pkg::COLS,
    parameter int ROWS = systolic_pkg::ROWS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [COLS-1:0]         sys_in,
    systolic_drain_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    input  logic                    clear_ovf
);

    // Skew range follows the actual geometry, not just the package default.
    localparam int SKEW_END = ROWS + COLS - 2;
    localparam int K_W      = $clog2(SKEW_END + 1);
    localparam int ROW_W    = $clog2(ROWS);

    state_t             r_state, w_state_nxt;
    logic [K_W-1:0]     r_k, w_k_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic               r_done, w_done_nxt;
    logic               r_ovf;
    logic               w_ovf_set;
    logic               w_cap_en;
    logic [K_W-1:0]     w_cap_k;
    logic               w_accept;
    logic               w_valid;
    logic [COLS-1:0]    w_rd_data;

    deskew_buffer #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .K_W   (K_W),
        .ROW_W (ROW_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_cap_en),
        .i_k       (w_cap_k),
        .i_sys_in  (sys_in),
        .i_rd_row  (r_row),
        .o_rd_data (w_rd_data)
    );

    assign w_valid  = (r_state == DRAIN);
    assign w_accept = w_valid && bus.out_ready;

    // Next-state, counter and capture decode. A start outside IDLE is dropped
    // and only flags overflow. Skew index 0 is captured in the start cycle so
    // CAPTURE begins at k=1.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_row_nxt   = r_row;
        w_done_nxt  = 1'b0;
        w_cap_en    = 1'b0;
        w_cap_k     = '0;
        w_ovf_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cap_en    = 1'b1;
                    w_cap_k     = '0;
                    w_k_nxt     = K_W'(1);
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_cap_en  = 1'b1;
                w_cap_k   = r_k;
                w_ovf_set = start;
                if (r_k == K_W'(SKEW_END)) begin
                    w_k_nxt     = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            DRAIN: begin
                w_ovf_set = start;
                if (w_accept) begin
                    if (r_row == ROW_W'(ROWS - 1)) begin
                        w_row_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_row_nxt = r_row + ROW_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state, counters and the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_row   <= w_row_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Sticky overflow; a dropped start in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // The buffer is frozen during DRAIN, so the presented row stays stable
    // under backpressure; data is forced to zero when nothing is offered.
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_rd_data : '0;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: table-driven identity run,
// hand-written backpressure / overflow / reset sequences, and randomized
// matrices checked against a skewed-wavefront reference model.
module tb_systolic_drain;

    typedef logic [7:0] mat_t [8];

    typedef struct {
        bit         st;
        logic [7:0] sys;
        bit         rdy;
        bit         e_vld;
        logic [7:0] e_data;
        bit         e_busy;
        bit         e_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_start;
    logic [7:0] d_sys;
    logic       d_ready;
    logic       d_clr;
    logic       busy;
    logic       done;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_drain_if #(.COLS(8)) bus ();
    assign bus.out_ready = d_ready;

    systolic_drain #(.COLS(8), .ROWS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (d_start),
        .sys_in    (d_sys),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .clear_ovf (d_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference for the array output: column j shows row c-j of the matrix
    // c cycles after start; anything outside that window is junk.
    function automatic logic [7:0] skew_in(input mat_t m, input int c, input int junk);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            int k;
            k = c - j;
            if (c >= 0 && c <= 14 && k >= 0 && k < 8) b[j] = m[k][j];
            else if (junk == 0) b[j] = 1'b0;
            else if (junk == 1) b[j] = 1'b1;
            else b[j] = 1'($urandom_range(1));
        end
        return b;
    endfunction

    task automatic idle_junk(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            d_start = 1'b0;
            d_sys   = val;
            d_ready = 1'b1;
            step();
        end
    endtask

    // One full operation with random readiness; every accepted byte is
    // compared with the next expected row and done must follow row 7.
    task automatic run_op(input mat_t m, input int rdy_pct, input int junk, input string tag);
        int         row;
        bit         got_done;
        bit         hold;
        logic [7:0] prev;
        row = 0; got_done = 0; hold = 0; prev = '0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            d_start = (c == 0);
            d_sys   = skew_in(m, c, junk);
            d_ready = ($urandom_range(99) < rdy_pct);
            d_clr   = 1'b0;
            settle();
            if (c == 0) begin
                chk({tag, "_idle_valid"}, bus.out_valid, 0);
                chk({tag, "_idle_busy"}, busy, 0);
            end
            if (hold) begin
                chk({tag, "_hold_valid"}, bus.out_valid, 1);
                chk({tag, "_hold_data"}, bus.out_data, prev);
            end
            if (!bus.out_valid && bus.out_data != 8'h00)
                chk({tag, "_data_zero"}, bus.out_data, 0);
            if (bus.out_valid && d_ready) begin
                if (row < 8) chk({tag, "_row"}, bus.out_data, m[row]);
                else chk({tag, "_extra_row"}, row, 7);
                row++;
            end
            hold = bus.out_valid && !d_ready;
            prev = bus.out_data;
            if (done) begin
                chk({tag, "_rows_at_done"}, row, 8);
                got_done = 1;
            end
            step();
        end
        if (!got_done) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    function automatic int bp_row(input int c);
        if (c == 15) return 0;
        if (c == 16) return 1;
        if (c >= 17 && c <= 20) return 2;
        if (c >= 21 && c <= 25) return c - 18;
        return -1;
    endfunction

    initial begin
        vec_t tbl [25];
        mat_t m;
        mat_t ones;
        mat_t zeros;
        bit   saw_done;
        bit   fin;

        // Identity-matrix vectors derived from the timing rules.
        for (int c = 0; c < 25; c++) begin
            tbl[c].st     = (c == 0);
            tbl[c].sys    = (c % 2 == 0 && c / 2 < 8) ? 8'(1 << (c / 2)) : 8'h00;
            tbl[c].rdy    = 1'b1;
            tbl[c].e_vld  = (c >= 15 && c <= 22);
            tbl[c].e_data = (c >= 15 && c <= 22) ? 8'(1 << (c - 15)) : 8'h00;
            tbl[c].e_busy = (c >= 1 && c <= 22);
            tbl[c].e_done = (c == 23);
        end
        for (int r = 0; r < 8; r++) begin
            ones[r]  = 8'hFF;
            zeros[r] = 8'h00;
        end

        rst_n = 1'b0; d_start = 0; d_sys = '0; d_ready = 0; d_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        settle();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        step();
        rst_n = 1'b1;
        step();

        for (int c = 0; c < 25; c++) begin
            d_start = tbl[c].st;
            d_sys   = tbl[c].sys;
            d_ready = tbl[c].rdy;
            settle();
            chk($sformatf("id_valid_c%0d", c), bus.out_valid, tbl[c].e_vld);
            chk($sformatf("id_data_c%0d", c), bus.out_data, tbl[c].e_data);
            chk($sformatf("id_busy_c%0d", c), busy, tbl[c].e_busy);
            chk($sformatf("id_done_c%0d", c), done, tbl[c].e_done);
            step();
        end

        // All-ones with ones outside the window, then all-zeros with the
        // same junk: any out-of-window write would leave a stray 1.
        idle_junk(3, 8'hFF);
        run_op(ones, 100, 1, "ones");
        idle_junk(2, 8'hFF);
        run_op(zeros, 100, 1, "zeros");
        idle_junk(2, 8'h00);

        // Backpressure on row 2 for three cycles.
        for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
        for (int c = 0; c < 28; c++) begin
            d_start = (c == 0);
            d_sys   = skew_in(m, c, 2);
            d_ready = !(c >= 17 && c <= 19);
            settle();
            if (bp_row(c) >= 0) begin
                chk($sformatf("bp_valid_c%0d", c), bus.out_valid, 1);
                chk($sformatf("bp_data_c%0d", c), bus.out_data, m[bp_row(c)]);
            end else begin
                chk($sformatf("bp_novalid_c%0d", c), bus.out_valid, 0);
            end
            chk($sformatf("bp_done_c%0d", c), done, (c == 26));
            step();
        end

        // Dropped starts in CAPTURE and in the final handshake cycle.
        for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
        for (int c = 0; c < 24; c++) begin
            d_start = (c == 0 || c == 5 || c == 22);
            d_sys   = skew_in(m, c, 2);
            d_ready = 1'b1;
            settle();
            if (c == 5) chk("ovf_before", overflow, 0);
            if (c == 6) chk("ovf_set", overflow, 1);
            if (c >= 15 && c <= 22) chk($sformatf("ovf_row_c%0d", c), bus.out_data, m[c - 15]);
            if (c == 23) begin
                chk("ovf_done", done, 1);
                chk("ovf_still", overflow, 1);
                chk("ovf_idle", busy, 0);
            end
            step();
        end
        d_start = 1; d_sys = '0; step();
        d_start = 1; d_clr = 1; step();
        d_start = 0; d_clr = 1;
        settle();
        chk("ovf_set_wins", overflow, 1);
        step();
        d_clr = 0;
        settle();
        chk("ovf_cleared", overflow, 0);
        fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            settle();
            if (done) fin = 1;
            step();
        end
        if (!fin) chk("ovf_drain_timeout", 0, 1);

        // Asynchronous reset in the middle of a capture.
        for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            d_start = (c == 0 || c == 3);
            d_sys   = skew_in(m, c, 2);
            settle();
            if (c == 7) begin
                chk("mid_busy_before", busy, 1);
                chk("mid_ovf_before", overflow, 1);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_ovf", overflow, 0);
                chk("mid_rst_valid", bus.out_valid, 0);
                chk("mid_rst_data", bus.out_data, 0);
                chk("mid_rst_done", done, 0);
            end
            step();
        end
        d_start = 0;
        step();
        rst_n = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (done || busy) saw_done = 1;
            step();
        end
        chk("mid_no_done", saw_done, 0);
        for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
        run_op(m, 100, 2, "after_rst");

        // Random matrices, random readiness and random junk.
        for (int t = 0; t < 55; t++) begin
            for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
            run_op(m, 30 + $urandom_range(70), 2, $sformatf("rnd%0d", t));
            if ($urandom_range(1) == 1) idle_junk($urandom_range(3), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output-side companion to the 8-column 1-bit systolic cell array.
- The array emits result bits skewed in time: column j lags column 0 by j cycles. This block de-skews them into an 8x8 bit matrix.
- It then streams the matrix out one row-byte at a time over a valid/ready handshake, toward uo_out or downstream logic.
- It is the reader for the array's writer side.

Parameters:
- COLS, 8, number of array columns; also the output byte width.
- ROWS, 8, number of result rows captured per wavefront.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  pulse marking the first wavefront: row 0 / column 0 is on sys_in[0] this cycle.
- sys_in  input  COLS  last-row outputs of the systolic array, one bit per column.
- out_data  output  COLS  current row byte; bit j = column j.
- out_valid  output  1  out_data holds an unconsumed row.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  capture or drain in progress.
- done  output  1  one-cycle pulse after the last row is accepted.
- overflow  output  1  sticky: a start was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Reset: async on rst_n low. out_data=0, out_valid=0, busy=0, done=0, overflow=0, state=IDLE, all counters 0, buffer cleared.
- Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start=1 captures skew index k=0 in the same cycle.
  - Next state CAPTURE with k=1.
- Capture rule: at skew index k (0..ROWS+COLS-2), for every column j with 0 <= k-j < ROWS, write buf[k-j][j] <= sys_in[j]. All other bits are untouched.
- CAPTURE:
  - k increments each cycle.
  - After the cycle with k = ROWS+COLS-2 (=14), go to DRAIN with row=0.
- DRAIN:
  - out_valid=1, out_data=buf[row].
  - On out_valid && out_ready: row increments.
  - On acceptance of row ROWS-1: go to IDLE and register done=1 for the following cycle.
- out_data is 0 whenever out_valid=0.
- While out_valid=1 and out_ready=0, out_data is held stable.
- Timing, with start in cycle 0 and out_ready held high:
  - out_valid is high in cycles 15..22, carrying rows 0..7.
  - done=1 in cycle 23.
  - busy=1 in cycles 1..22; busy=(state!=IDLE).
- start in CAPTURE or DRAIN (including the final-handshake cycle) is ignored and sets overflow. The operation in progress is unaffected.
- overflow clears on clear_ovf=1. If set and clear occur in the same cycle, set wins.
- sys_in is ignored outside the capture window.
- The buffer is not cleared between operations. Every bit is overwritten exactly once per capture.

Decomposition:
- Shared package systolic_pkg holds:
  - the ROWS and COLS defaults;
  - the state enum {IDLE, CAPTURE, DRAIN};
  - SKEW_LAST = ROWS+COLS-2.
- The array feeder block reuses this package.
- One sub-module, deskew_buffer, holds the ROWS x COLS bit storage, the per-bit write-enable decode from k, and the row read mux.
- The FSM, counters and handshake stay in systolic_drain.

Test Plan:
- Identity matrix: start in cycle 0, sys_in[j]=1 only at cycle 2j, out_ready=1 → bytes 0x01,0x02,0x04,...,0x80 in cycles 15..22; done=1 in cycle 23; busy low in cycles 0 and 23.
- All-ones wavefront: sys_in=0xFF in cycles 0..14 with junk 0xFF before and after the window → eight 0xFF bytes; buffer unchanged by bits outside the window (check with a following all-zero run giving eight 0x00 bytes).
- Backpressure: out_ready low for 3 cycles while row 2 is presented → out_data stable at row 2 value, out_valid stays 1; all 8 rows still delivered in order; done delayed by 3 cycles (cycle 26).
- Overflow: second start at cycle 5, and again at cycle 22 (final handshake) → overflow=1 from cycle 6, output rows match the first wavefront only; clear_ovf together with a new dropped start keeps overflow=1; clear_ovf alone clears it next cycle.
- Reset mid-capture: rst_n low at cycle 7 → all outputs 0 immediately (asynchronous), no done pulse; a fresh start after release produces the correct 8 rows.
- Random 8x8 matrices (≥50), random out_ready → scoreboard compares against a model of the skewed wavefront; every matrix delivered exactly once.
